cobra_io_responder: RTL and testbench

- Z80 I/O-space responder for the Cobra1 core. Sits on the tv80s bus opposite the CPU.
- Answers IORQ read cycles with keyboard matrix data, or 0xFF for unmapped ports.
- Decodes the OUT (1F) write into a one-cycle reloc-clear pulse.
- A host/testbench injects key press/release events through a valid/ready FIFO. Events are applied to the matrix paced by a hold counter, so Monitor scan loops see every change.

---
 rtl/cobra_io_pkg.sv | 30 +++
 rtl/key_event_fifo.sv | 64 ++++++
 rtl/cobra_io_responder.sv | 157 +++++++++++++++
 tb/tb_cobra_io_responder.sv | 393 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cobra_io_pkg.sv
// Shared types and constants for the Cobra1 I/O-space responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: keyboard matrix geometry, key event payload, apply FSM states,
// the value returned for unmapped ports, and a column range helper.
package cobra_io_pkg;

    localparam int KEY_ROWS = 8;
    localparam int KEY_COLS = 5;

    localparam logic [7:0] IO_UNMAPPED = 8'hFF;

    typedef struct packed {
        logic       press;
        logic [2:0] row;
        logic [2:0] col;
    } key_event_t;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } apply_state_t;

    // Only columns 0..4 exist; events naming columns 5..7 are discarded.
    function automatic logic col_in_range(input logic [2:0] col);
        return col < 3'(KEY_COLS);
    endfunction

endpackage

// File: rtl/key_event_fifo.sv
// Synchronous FIFO holding key_event_t entries between host and apply FSM.
// Latency: entry pushed on edge N is visible at pop_dat (fall-through) after edge N.
// Backpressure: full blocks pushes (ignored when full); pop ignored when empty.
//
// Ports: clk, rst_n (async active-low); push/push_dat write side;
// pop/pop_dat read side; full, empty, count status.
module key_event_fifo
    import cobra_io_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  key_event_t               push_dat,
    input  logic                     pop,
    output key_event_t               pop_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int              PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0]  FULL_CNT = (PTR_W + 1)'(DEPTH);

    key_event_t         r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W:0]     r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign full      = (r_count == FULL_CNT);
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign pop_dat   = r_mem[r_rd_ptr];
    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & ~empty;

    // Storage needs no reset: contents are only observed when count says valid.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_dat;
        end
    end

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/cobra_io_responder.sv
// Z80 I/O responder: keyboard matrix reads, reloc-clear OUT pulse, paced key injection.
// Latency: reads combinational; reloc_clear 1 clk after write strobe; key push->matrix 2 clks min.
// Backpressure: key_ready = FIFO not full; pops stall during HOLD and while an IN cycle is active.
//
// Ports: clk, reset_n (async active-low); CPU bus addr/iorq_n/rd_n/wr_n/m1_n/data_in;
// data_out/data_oe read return; reloc_clear pulse; key_valid/key_ready/key_code/key_press host events.
// Optional macro COBRA_KBD_STATUS_EN maps a status register at KBD_PORT+1.
module cobra_io_responder
    import cobra_io_pkg::*;
#(
    parameter logic [7:0]  KBD_PORT    = 8'h1F,
    parameter int          FIFO_DEPTH  = 4,
    parameter logic [15:0] HOLD_CYCLES = 16'd2000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] addr,
    input  logic        iorq_n,
    input  logic        rd_n,
    input  logic        wr_n,
    input  logic        m1_n,
    input  logic [7:0]  data_in,
    output logic [7:0]  data_out,
    output logic        data_oe,
    output logic        reloc_clear,
    input  logic        key_valid,
    output logic        key_ready,
    input  logic [5:0]  key_code,
    input  logic        key_press
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic                                 w_io_rd;
    logic                                 w_io_wr;
    logic                                 w_wr_hit;
    logic                                 w_push;
    logic                                 w_pop;
    logic                                 w_full;
    logic                                 w_empty;
    logic [CNT_W-1:0]                     w_count;
    key_event_t                           w_push_dat;
    key_event_t                           w_pop_dat;
    logic [KEY_COLS-1:0]                  w_kbd_cols;
    logic                                 w_unused;

    apply_state_t                         r_state;
    logic [15:0]                          r_hold_cnt;
    logic [KEY_ROWS-1:0][KEY_COLS-1:0]    r_matrix;
    logic                                 r_wr_hit_d;
    logic                                 r_reloc_clear;

    // Bus decode is gated by reset so nothing is driven onto cpu_din in reset.
    assign w_io_rd  = reset_n & ~iorq_n & ~rd_n & m1_n;
    assign w_io_wr  = reset_n & ~iorq_n & ~wr_n & m1_n;
    assign w_wr_hit = w_io_wr & (addr[7:0] == KBD_PORT);

    assign data_oe     = w_io_rd;
    assign reloc_clear = r_reloc_clear;
    assign key_ready   = reset_n & ~w_full;
    assign w_push      = key_valid & key_ready;
    assign w_push_dat  = {key_press, key_code};
    // Popping during an IN cycle would change data_out mid-read.
    assign w_pop       = (r_state == IDLE) & ~w_empty & ~w_io_rd;

    key_event_fifo #(
        .DEPTH    (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (reset_n),
        .push     (w_push),
        .push_dat (w_push_dat),
        .pop      (w_pop),
        .pop_dat  (w_pop_dat),
        .full     (w_full),
        .empty    (w_empty),
        .count    (w_count)
    );

    // Row selects are active-low on the high address byte; columns read active-low.
    always_comb begin
        w_kbd_cols = '1;
        for (int r = 0; r < KEY_ROWS; r++) begin
            if (!addr[8 + r]) begin
                w_kbd_cols = w_kbd_cols & ~r_matrix[r];
            end
        end
    end

`ifdef COBRA_KBD_STATUS_EN
    localparam logic [7:0] STATUS_PORT = KBD_PORT + 8'd1;

    logic [3:0] w_status_cnt;
    assign w_status_cnt = 4'(w_count);

    always_comb begin
        data_out = IO_UNMAPPED;
        if (w_io_rd && (addr[7:0] == KBD_PORT)) begin
            data_out = {3'b111, w_kbd_cols};
        end else if (w_io_rd && (addr[7:0] == STATUS_PORT)) begin
            data_out = {1'b0, w_status_cnt, (r_state == HOLD), (|r_matrix), w_full};
        end
    end

    assign w_unused = ^data_in;
`else
    always_comb begin
        data_out = IO_UNMAPPED;
        if (w_io_rd && (addr[7:0] == KBD_PORT)) begin
            data_out = {3'b111, w_kbd_cols};
        end
    end

    assign w_unused = ^{data_in, w_count};
`endif

    // Edge detect so a write held across wait states yields a single pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_hit_d    <= 1'b0;
            r_reloc_clear <= 1'b0;
        end else begin
            r_wr_hit_d    <= w_wr_hit;
            r_reloc_clear <= w_wr_hit & ~r_wr_hit_d;
        end
    end

    // Apply FSM. Leaving HOLD as the counter reaches zero makes consecutive
    // applies exactly HOLD_CYCLES edges apart.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_hold_cnt <= '0;
            r_matrix   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pop && col_in_range(w_pop_dat.col)) begin
                        r_matrix[w_pop_dat.row][w_pop_dat.col] <= w_pop_dat.press;
                        if (HOLD_CYCLES > 16'd1) begin
                            r_hold_cnt <= HOLD_CYCLES - 16'd1;
                            r_state    <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    r_hold_cnt <= r_hold_cnt - 16'd1;
                    if (r_hold_cnt <= 16'd1) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cobra_io_responder.sv
// Directed bench for cobra_io_responder (HOLD_CYCLES=4, FIFO_DEPTH=4).
// Latency: n/a.
// Backpressure: host-side pushes wait on key_ready with a bounded loop.
module tb_cobra_io_responder;

    logic        clk;
    logic        reset_n;
    logic [15:0] addr;
    logic        iorq_n;
    logic        rd_n;
    logic        wr_n;
    logic        m1_n;
    logic [7:0]  data_in;
    logic [7:0]  data_out;
    logic        data_oe;
    logic        reloc_clear;
    logic        key_valid;
    logic        key_ready;
    logic [5:0]  key_code;
    logic        key_press;

    int checks;
    int failures;

    cobra_io_responder #(
        .KBD_PORT    (8'h1F),
        .FIFO_DEPTH  (4),
        .HOLD_CYCLES (16'd4)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .addr        (addr),
        .iorq_n      (iorq_n),
        .rd_n        (rd_n),
        .wr_n        (wr_n),
        .m1_n        (m1_n),
        .data_in     (data_in),
        .data_out    (data_out),
        .data_oe     (data_oe),
        .reloc_clear (reloc_clear),
        .key_valid   (key_valid),
        .key_ready   (key_ready),
        .key_code    (key_code),
        .key_press   (key_press)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Short IN cycle entirely between clock edges: never blocks a pop.
    task automatic probe(input logic [15:0] a, output logic [7:0] d, output logic oe);
        addr   = a;
        iorq_n = 1'b0;
        rd_n   = 1'b0;
        #1;
        d      = data_out;
        oe     = data_oe;
        iorq_n = 1'b1;
        rd_n   = 1'b1;
        #1;
    endtask

    // Presents one event and returns just after the edge that accepted it.
    task automatic push_key(input logic [5:0] code, input logic press);
        int k;
        key_code  = code;
        key_press = press;
        key_valid = 1'b1;
        k = 0;
        while (!key_ready && k < 50) begin
            step(1);
            k++;
        end
        if (!key_ready) begin
            checks++;
            failures++;
            $display("FAIL push_timeout: key_ready=%b required 1 within 50 cycles", key_ready);
        end
        step(1);
        key_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] d;
        logic       oe;
        reset_n = 1'b0;
        #2;
        checks++;
        if (key_ready !== 1'b0) begin failures++; $display("FAIL rst_key_ready: got %b expected 0", key_ready); end
        checks++;
        if (reloc_clear !== 1'b0) begin failures++; $display("FAIL rst_reloc: got %b expected 0", reloc_clear); end
        probe(16'h001F, d, oe);
        checks++;
        if (oe !== 1'b0) begin failures++; $display("FAIL rst_data_oe: got %b expected 0", oe); end
        checks++;
        if (d !== 8'hFF) begin failures++; $display("FAIL rst_data_out: got %h expected ff", d); end
        step(2);
        reset_n = 1'b1;
        step(1);
        checks++;
        if (key_ready !== 1'b1) begin failures++; $display("FAIL post_rst_key_ready: got %b expected 1", key_ready); end
        checks++;
        if (data_oe !== 1'b0) begin failures++; $display("FAIL idle_data_oe: got %b expected 0", data_oe); end
    endtask

    task automatic test_unmapped();
        logic [7:0] d;
        logic       oe;
        probe(16'hFE1F, d, oe);
        checks++;
        if (oe !== 1'b1) begin failures++; $display("FAIL kbd_read_oe: got %b expected 1", oe); end
        checks++;
        if (d !== 8'hFF) begin failures++; $display("FAIL kbd_read_empty: got %h expected ff", d); end
        probe(16'h0020, d, oe);
        checks++;
        if (d !== 8'hFF) begin failures++; $display("FAIL port20_unmapped: got %h expected ff", d); end
        probe(16'h0000, d, oe);
        checks++;
        if (d !== 8'hFF) begin failures++; $display("FAIL port00_unmapped: got %h expected ff", d); end
    endtask

    task automatic test_single_press();
        logic [7:0] d;
        logic       oe;
        push_key(6'o02, 1'b1);
        probe(16'hFE1F, d, oe);
        checks++;
        if (d !== 8'hFF) begin failures++; $display("FAIL press_too_early: got %h expected ff", d); end
        step(1);
        probe(16'hFE1F, d, oe);
        checks++;
        if (d !== 8'hFB) begin failures++; $display("FAIL press_latency2: got %h expected fb", d); end
        step(2);
        probe(16'hFE1F, d, oe);
        checks++;
        if (d !== 8'hFB) begin failures++; $display("FAIL press_row0: got %h expected fb", d); end
        probe(16'hFD1F, d, oe);
        checks++;
        if (d !== 8'hFF) begin failures++; $display("FAIL press_row1: got %h expected ff", d); end
        push_key(6'o02, 1'b0);
        step(10);
        probe(16'hFE1F, d, oe);
        checks++;
        if (d !== 8'hFF) begin failures++; $display("FAIL release_row0: got %h expected ff", d); end
    endtask

    task automatic test_back_to_back();
        logic [5:0] codes [5];
        logic       presses [5];
        logic [7:0] exp_vals [5];
        int         chg_cyc [$];
        logic [7:0] chg_val [$];
        logic [7:0] last;
        logic [7:0] d;
        logic       oe;
        logic       accept;
        codes    = '{6'o00, 6'o01, 6'o14, 6'o00, 6'o01};
        presses  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        exp_vals = '{8'hFE, 8'hFC, 8'hEC, 8'hED, 8'hEF};
        step(10);
        // A held read on an unmapped port keeps the FSM from popping.
        addr   = 16'h0020;
        iorq_n = 1'b0;
        rd_n   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            key_code  = codes[i];
            key_press = presses[i];
            key_valid = 1'b1;
            checks++;
            if (key_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_%0d: got %b expected 1", i, key_ready); end
            step(1);
        end
        key_code  = codes[4];
        key_press = presses[4];
        checks++;
        if (key_ready !== 1'b0) begin failures++; $display("FAIL b2b_full: key_ready=%b expected 0", key_ready); end
        step(2);
        checks++;
        if (key_ready !== 1'b0) begin failures++; $display("FAIL b2b_full_hold: key_ready=%b expected 0", key_ready); end
        checks++;
        if (data_out !== 8'hFF) begin failures++; $display("FAIL b2b_blocked_read: got %h expected ff", data_out); end
        iorq_n = 1'b1;
        rd_n   = 1'b1;
        last = 8'hFF;
        for (int c = 1; c <= 24; c++) begin
            accept = key_valid & key_ready;
            step(1);
            if (accept) key_valid = 1'b0;
            probe(16'hFC1F, d, oe);
            if (d !== last) begin
                chg_cyc.push_back(c);
                chg_val.push_back(d);
                last = d;
            end
        end
        checks++;
        if (key_valid !== 1'b0) begin failures++; $display("FAIL b2b_fifth_push: key_valid=%b expected 0 (accepted)", key_valid); end
        checks++;
        if (chg_cyc.size() != 5) begin failures++; $display("FAIL b2b_change_count: got %0d expected 5", chg_cyc.size()); end
        for (int i = 0; i < 5 && i < chg_cyc.size(); i++) begin
            checks++;
            if (chg_val[i] !== exp_vals[i]) begin
                failures++;
                $display("FAIL b2b_value_%0d: got %h expected %h", i, chg_val[i], exp_vals[i]);
            end
            checks++;
            if (chg_cyc[i] != 1 + 4 * i) begin
                failures++;
                $display("FAIL b2b_cycle_%0d: got %0d expected %0d", i, chg_cyc[i], 1 + 4 * i);
            end
        end
    endtask

    task automatic test_read_hold();
        logic [7:0] d;
        logic       oe;
        int         bad;
        step(10);
        addr   = 16'hFB1F;
        iorq_n = 1'b0;
        rd_n   = 1'b0;
        push_key(6'o23, 1'b1);
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            step(1);
            if (data_oe !== 1'b1 || data_out !== 8'hFF) bad++;
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL hold_read_stable: %0d unstable cycles expected 0", bad); end
        iorq_n = 1'b1;
        rd_n   = 1'b1;
        #1;
        checks++;
        if (data_oe !== 1'b0) begin failures++; $display("FAIL hold_read_oe_drop: got %b expected 0", data_oe); end
        probe(16'hFB1F, d, oe);
        checks++;
        if (d !== 8'hFF) begin failures++; $display("FAIL hold_read_before_edge: got %h expected ff", d); end
        step(1);
        probe(16'hFB1F, d, oe);
        checks++;
        if (d !== 8'hF7) begin failures++; $display("FAIL hold_read_applied: got %h expected f7", d); end
    endtask

    task automatic test_bad_col();
        logic [7:0] d;
        logic       oe;
        push_key(6'o23, 1'b0);
        push_key(6'o14, 1'b0);
        step(10);
        probe(16'h001F, d, oe);
        checks++;
        if (d !== 8'hFF) begin failures++; $display("FAIL matrix_cleared: got %h expected ff", d); end
        push_key(6'o07, 1'b1);
        push_key(6'o11, 1'b1);
        probe(16'h001F, d, oe);
        checks++;
        if (d !== 8'hFF) begin failures++; $display("FAIL bad_col_ignored: got %h expected ff", d); end
        step(1);
        probe(16'h001F, d, oe);
        checks++;
        if (d !== 8'hFD) begin failures++; $display("FAIL bad_col_no_hold: got %h expected fd", d); end
        push_key(6'o11, 1'b0);
        step(10);
    endtask

    task automatic test_reloc();
        int bad;
        int pulses;
        addr    = 16'h001F;
        data_in = 8'hA5;
        iorq_n  = 1'b0;
        wr_n    = 1'b0;
        bad     = 0;
        for (int c = 1; c <= 8; c++) begin
            step(1);
            if (c == 4) begin
                iorq_n = 1'b1;
                wr_n   = 1'b1;
            end
            checks++;
            if (reloc_clear !== (c == 1)) begin
                failures++;
                $display("FAIL reloc_cycle_%0d: got %b expected %b", c, reloc_clear, (c == 1));
            end
        end
        addr   = 16'h001E;
        iorq_n = 1'b0;
        wr_n   = 1'b0;
        pulses = 0;
        for (int c = 0; c < 6; c++) begin
            step(1);
            if (reloc_clear) pulses++;
        end
        iorq_n = 1'b1;
        wr_n   = 1'b1;
        checks++;
        if (pulses != 0) begin failures++; $display("FAIL reloc_port1e: got %0d pulses expected 0", pulses); end
        addr   = 16'h001F;
        m1_n   = 1'b0;
        iorq_n = 1'b0;
        rd_n   = 1'b0;
        #1;
        checks++;
        if (data_oe !== 1'b0) begin failures++; $display("FAIL intack_oe: got %b expected 0", data_oe); end
        checks++;
        if (data_out !== 8'hFF) begin failures++; $display("FAIL intack_data: got %h expected ff", data_out); end
        rd_n   = 1'b1;
        wr_n   = 1'b0;
        pulses = 0;
        for (int c = 0; c < 4; c++) begin
            step(1);
            if (reloc_clear) pulses++;
        end
        checks++;
        if (pulses != 0) begin failures++; $display("FAIL intack_reloc: got %0d pulses expected 0", pulses); end
        iorq_n = 1'b1;
        wr_n   = 1'b1;
        m1_n   = 1'b1;
        bad    = 0;
        step(2);
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        logic       oe;
        step(10);
        push_key(6'o00, 1'b1);
        push_key(6'o01, 1'b1);
        push_key(6'o02, 1'b1);
        probe(16'hFE1F, d, oe);
        checks++;
        if (d !== 8'hFE) begin failures++; $display("FAIL mid_first_applied: got %h expected fe", d); end
        reset_n = 1'b0;
        #1;
        checks++;
        if (key_ready !== 1'b0) begin failures++; $display("FAIL mid_rst_key_ready: got %b expected 0", key_ready); end
        probe(16'hFE1F, d, oe);
        checks++;
        if (d !== 8'hFF) begin failures++; $display("FAIL mid_rst_data: got %h expected ff", d); end
        checks++;
        if (oe !== 1'b0) begin failures++; $display("FAIL mid_rst_oe: got %b expected 0", oe); end
        step(2);
        reset_n = 1'b1;
        step(20);
        probe(16'hFE1F, d, oe);
        checks++;
        if (d !== 8'hFF) begin failures++; $display("FAIL mid_rst_row0_after: got %h expected ff", d); end
        probe(16'h001F, d, oe);
        checks++;
        if (d !== 8'hFF) begin failures++; $display("FAIL mid_rst_all_after: got %h expected ff", d); end
        checks++;
        if (key_ready !== 1'b1) begin failures++; $display("FAIL mid_rst_ready_after: got %b expected 1", key_ready); end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        reset_n   = 1'b0;
        addr      = 16'h0000;
        iorq_n    = 1'b1;
        rd_n      = 1'b1;
        wr_n      = 1'b1;
        m1_n      = 1'b1;
        data_in   = 8'h00;
        key_valid = 1'b0;
        key_code  = 6'o00;
        key_press = 1'b0;

        test_reset();
        test_unmapped();
        test_single_press();
        test_back_to_back();
        test_read_hold();
        test_bad_col();
        test_reloc();
        test_reset_mid();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
